// File: rtl/mines_pkg.sv
// Shared types and constants for the Thanos mine scheduler.
// Positions are signed fixed point with 6 fractional bits (x64).
package mines_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int FP_SHIFT = 6;

    localparam int X_MIN    = 32;
    localparam int X_MAX    = 448;
    localparam int Y_START  = 32;
    localparam int Y_BOTTOM = 416;

    localparam int X_SPAN = X_MAX - X_MIN;

    typedef enum logic [2:0] {
        IDLE_ST,
        WAIT_ST,
        SPAWN_ST,
        UPDATE_ST,
        LIMITS_ST
    } sched_state_t;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
    } slot_pos_t;

    // Offsets past the playfield span fold back by 256 px,
    // keeping every spawn inside [X_MIN, X_MAX].
    function automatic logic signed [31:0] spawn_x(
        input logic [15:0] lfsr
    );
        logic [8:0]         off;
        logic signed [31:0] px;
        off = lfsr[8:0];
        if (off > 9'(X_SPAN))
            off = off - 9'd256;
        px = 32'(X_MIN) + 32'(off);
        return px <<< FP_SHIFT;
    endfunction

    function automatic logic [10:0] to_pixels(
        input logic signed [31:0] v
    );
        return 11'(v >>> FP_SHIFT);
    endfunction

endpackage

// File: rtl/mines_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), steps every clock.
// Ports: clk, resetN (async low), value (current register).
module mines_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetN,
    output logic [15:0] value
);

    logic fb;

    assign fb = value[15] ^ value[13] ^ value[12] ^ value[10];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            value <= SEED;
        else
            value <= {value[14:0], fb};
    end

endmodule

// File: rtl/thanos_mines_scheduler.sv
// Frame-driven mine pool: spawns, moves and retires mines through
// one shared update/limit datapath walked slot by slot each frame.
// Ports: clk, resetN, startOfFrame, enable, hitValid/hitSlot in;
// mineActive, topLeftX/Y (11 bits per slot), mineLanded, busy out.
module thanos_mines_scheduler
    import mines_pkg::*;
#(
    parameter int          NUM_MINES    = 4,
    parameter int          SPAWN_PERIOD = 60,
    parameter int          FALL_SPEED   = 64,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic                         enable,
    input  logic                         hitValid,
    input  logic [$clog2(NUM_MINES)-1:0] hitSlot,
    output logic [NUM_MINES-1:0]         mineActive,
    output logic [NUM_MINES*11-1:0]      topLeftX,
    output logic [NUM_MINES*11-1:0]      topLeftY,
    output logic                         mineLanded,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_MINES);
    localparam int CNT_W =
        (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    localparam logic signed [31:0] Y_START_FP =
        32'(Y_START * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] Y_BOTTOM_FP =
        32'(Y_BOTTOM * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] FALL_FP = 32'(FALL_SPEED);

    sched_state_t state;
    sched_state_t next_state;

    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] spawnCnt;
    slot_pos_t        pos [NUM_MINES];
    logic [15:0]      lfsr;

    logic               spawn_due;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic signed [31:0] cur_y;
    logic signed [31:0] sum_y;
    logic               landing;
    logic               hit_here;
    logic               last_idx;

    mines_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .resetN (resetN),
        .value  (lfsr)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= IDLE_ST;
        else
            state <= next_state;
    end

    assign last_idx = (idx == IDX_W'(NUM_MINES - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE_ST,
            WAIT_ST: begin
                if (startOfFrame && enable)
                    next_state = SPAWN_ST;
            end
            SPAWN_ST:  next_state = UPDATE_ST;
            UPDATE_ST: next_state = LIMITS_ST;
            LIMITS_ST: begin
                if (last_idx)
                    next_state = WAIT_ST;
                else
                    next_state = UPDATE_ST;
            end
            default:   next_state = IDLE_ST;
        endcase
    end

    assign busy = (state == SPAWN_ST)
               || (state == UPDATE_ST)
               || (state == LIMITS_ST);

    assign spawn_due = (spawnCnt == CNT_W'(SPAWN_PERIOD - 1));

    // Walk downward so the lowest free index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_MINES - 1; i >= 0; i--) begin
            if (!mineActive[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // The single shared adder and comparator, steered by idx.
    assign cur_y    = pos[idx].y;
    assign sum_y    = cur_y + FALL_FP;
    assign landing  = mineActive[idx] && (cur_y > Y_BOTTOM_FP);
    assign hit_here = hitValid && (hitSlot == idx);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mineActive <= '0;
            idx        <= '0;
            spawnCnt   <= '0;
            mineLanded <= 1'b0;
            for (int i = 0; i < NUM_MINES; i++)
                pos[i] <= '0;
        end else begin
            mineLanded <= 1'b0;
            case (state)
                SPAWN_ST: begin
                    idx <= '0;
                    if (spawn_due) begin
                        spawnCnt <= '0;
                        if (free_found) begin
                            mineActive[free_idx] <= 1'b1;
                            pos[free_idx].x <= spawn_x(lfsr);
                            pos[free_idx].y <= Y_START_FP;
                        end
                    end else begin
                        spawnCnt <= spawnCnt + CNT_W'(1);
                    end
                end
                UPDATE_ST: begin
                    if (mineActive[idx])
                        pos[idx].y <= sum_y;
                end
                LIMITS_ST: begin
                    if (landing) begin
                        mineActive[idx] <= 1'b0;
                        mineLanded      <= !hit_here;
                    end
                    if (!last_idx)
                        idx <= idx + IDX_W'(1);
                end
                default: ;
            endcase
            // Placed last so a hit overrides spawn and retire alike.
            if (hitValid)
                mineActive[hitSlot] <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_MINES; g++) begin : g_out
        assign topLeftX[g*11 +: 11] = to_pixels(pos[g].x);
        assign topLeftY[g*11 +: 11] = to_pixels(pos[g].y);
    end

endmodule

// File: tb/tb_thanos_mines_scheduler.sv
// Directed bench for thanos_mines_scheduler: spawn, fall, landing,
// full pool, hit-vs-retire, mid-frame reset and disabled frames.
module tb_thanos_mines_scheduler;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        enable;
    logic        hitValid;
    logic [1:0]  hitSlot;

    logic [3:0]  mineActive;
    logic [43:0] topLeftX;
    logic [43:0] topLeftY;
    logic        mineLanded;
    logic        busy;

    logic [3:0]  b_mineActive;
    logic [43:0] b_topLeftX;
    logic [43:0] b_topLeftY;
    logic        b_mineLanded;
    logic        b_busy;

    int n_vec;
    int n_bad;
    int land_cnt;

    logic [15:0] lfsr_m;
    logic [15:0] spawn_lfsr;

    thanos_mines_scheduler #(
        .NUM_MINES    (4),
        .SPAWN_PERIOD (1),
        .FALL_SPEED   (64),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .enable       (enable),
        .hitValid     (hitValid),
        .hitSlot      (hitSlot),
        .mineActive   (mineActive),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .mineLanded   (mineLanded),
        .busy         (busy)
    );

    thanos_mines_scheduler #(
        .NUM_MINES    (4),
        .SPAWN_PERIOD (3),
        .FALL_SPEED   (64),
        .LFSR_SEED    (16'hACE1)
    ) dut3 (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .enable       (enable),
        .hitValid     (hitValid),
        .hitSlot      (hitSlot),
        .mineActive   (b_mineActive),
        .topLeftX     (b_topLeftX),
        .topLeftY     (b_topLeftY),
        .mineLanded   (b_mineLanded),
        .busy         (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN)
            lfsr_m <= 16'hACE1;
        else
            lfsr_m <= lfsr_step(lfsr_m);
    end

    always @(negedge clk) begin
        if (resetN && mineLanded)
            land_cnt <= land_cnt + 1;
    end

    initial land_cnt = 0;

    function automatic int exp_x(input logic [15:0] v);
        int off;
        off = int'(v[8:0]);
        if (off > 416)
            off = off - 256;
        return 32 + off;
    endfunction

    function automatic logic [10:0] xpix(input int i);
        return topLeftX[i*11 +: 11];
    endfunction

    function automatic logic [10:0] ypix(input int i);
        return topLeftY[i*11 +: 11];
    endfunction

    task automatic check_eq(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse startOfFrame and count busy cycles. hit_at / rst_at
    // pick the busy cycle (1 = SPAWN_ST) for a hit or a reset.
    task automatic do_frame(
        input  int         hit_at,
        input  logic [1:0] hslot,
        input  int         rst_at,
        output int         bcyc
    );
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        spawn_lfsr = lfsr_m;
        bcyc = 0;
        while (busy && bcyc < 40) begin
            bcyc++;
            hitValid = (bcyc == hit_at);
            hitSlot  = hslot;
            if (bcyc == rst_at)
                resetN = 1'b0;
            @(posedge clk); #1;
        end
        hitValid = 1'b0;
        if (bcyc >= 40)
            check_eq("frame_timeout", 64'(bcyc), 64'd9);
    endtask

    // Idle until the LFSR value seen in the next SPAWN_ST has
    // the requested low nine bits.
    task automatic seek(input logic [8:0] want);
        logic [15:0] nx;
        int n;
        n = 0;
        nx = lfsr_step(lfsr_m);
        while (nx[8:0] != want && n < 65536) begin
            @(posedge clk); #1;
            n++;
            nx = lfsr_step(lfsr_m);
        end
        if (n >= 65536)
            check_eq("seek_timeout", 64'(n), 64'd0);
    endtask

    int bc;
    int l0;
    int x2;

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        enable       = 1'b0;
        hitValid     = 1'b0;
        hitSlot      = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_active", 64'(mineActive), 64'd0);
        check_eq("rst_x", 64'(topLeftX), 64'd0);
        check_eq("rst_y", 64'(topLeftY), 64'd0);
        check_eq("rst_landed", 64'(mineLanded), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);

        resetN = 1'b1;
        @(posedge clk); #1;

        do_frame(0, 2'd0, 0, bc);
        check_eq("dis_busy", 64'(bc), 64'd0);
        check_eq("dis_active", 64'(mineActive), 64'd0);

        enable = 1'b1;

        seek(9'd450);
        do_frame(0, 2'd0, 0, bc);
        check_eq("f1_busy", 64'(bc), 64'd9);
        check_eq("f1_active", 64'(mineActive), 64'b0001);
        check_eq("f1_x0_fold", 64'(xpix(0)), 64'd226);
        check_eq("f1_y0", 64'(ypix(0)), 64'd33);
        check_eq("f1_p3_active", 64'(b_mineActive), 64'd0);

        seek(9'd0);
        do_frame(0, 2'd0, 0, bc);
        check_eq("f2_active", 64'(mineActive), 64'b0011);
        check_eq("f2_x1_min", 64'(xpix(1)), 64'd32);
        check_eq("f2_y1", 64'(ypix(1)), 64'd33);
        check_eq("f2_y0", 64'(ypix(0)), 64'd34);
        check_eq("f2_p3_active", 64'(b_mineActive), 64'd0);

        do_frame(0, 2'd0, 0, bc);
        x2 = exp_x(spawn_lfsr);
        check_eq("f3_active", 64'(mineActive), 64'b0111);
        check_eq("f3_x2", 64'(xpix(2)), 64'(x2));
        check_eq("f3_p3_active", 64'(b_mineActive), 64'b0001);
        check_eq("f3_p3_y0", 64'(b_topLeftY[10:0]), 64'd33);

        do_frame(0, 2'd0, 0, bc);
        check_eq("f4_active", 64'(mineActive), 64'b1111);
        check_eq("f4_x3", 64'(xpix(3)), 64'(exp_x(spawn_lfsr)));
        check_eq("f4_y0", 64'(ypix(0)), 64'd36);

        do_frame(0, 2'd0, 0, bc);
        check_eq("full_active", 64'(mineActive), 64'b1111);
        check_eq("full_x0", 64'(xpix(0)), 64'd226);
        check_eq("full_x2", 64'(xpix(2)), 64'(x2));
        check_eq("full_y3", 64'(ypix(3)), 64'd34);

        hitValid = 1'b1;
        hitSlot  = 2'd1;
        @(posedge clk); #1;
        hitValid = 1'b0;
        check_eq("idle_hit", 64'(mineActive), 64'b1101);

        do_frame(0, 2'd0, 0, bc);
        check_eq("refill_active", 64'(mineActive), 64'b1111);
        check_eq("refill_x1", 64'(xpix(1)), 64'(exp_x(spawn_lfsr)));
        check_eq("refill_y1", 64'(ypix(1)), 64'd33);
        check_eq("refill_y0", 64'(ypix(0)), 64'd38);

        l0 = land_cnt;
        for (int f = 7; f <= 384; f++)
            do_frame(0, 2'd0, 0, bc);
        check_eq("pre_land_y0", 64'(ypix(0)), 64'd416);
        check_eq("pre_land_cnt", 64'(land_cnt - l0), 64'd0);
        check_eq("pre_land_act", 64'(mineActive), 64'b1111);

        do_frame(0, 2'd0, 0, bc);
        @(posedge clk); #1;
        check_eq("land_pulses", 64'(land_cnt - l0), 64'd1);
        check_eq("land_active", 64'(mineActive), 64'b1110);
        check_eq("land_y0_hold", 64'(ypix(0)), 64'd417);
        check_eq("land_x0_hold", 64'(xpix(0)), 64'd226);
        check_eq("land_pulse_end", 64'(mineLanded), 64'd0);

        do_frame(0, 2'd0, 0, bc);
        check_eq("respawn_active", 64'(mineActive), 64'b1111);
        check_eq("respawn_y0", 64'(ypix(0)), 64'd33);
        check_eq("pre_hit_y2", 64'(ypix(2)), 64'd416);

        l0 = land_cnt;
        do_frame(7, 2'd2, 0, bc);
        @(posedge clk); #1;
        check_eq("hit_land_cnt", 64'(land_cnt - l0), 64'd0);
        check_eq("hit_land_act", 64'(mineActive), 64'b1011);
        check_eq("hit_land_y2", 64'(ypix(2)), 64'd417);

        do_frame(0, 2'd0, 4, bc);
        check_eq("mid_rst_cycles", 64'(bc), 64'd4);
        check_eq("mid_rst_active", 64'(mineActive), 64'd0);
        check_eq("mid_rst_x", 64'(topLeftX), 64'd0);
        check_eq("mid_rst_y", 64'(topLeftY), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_landed", 64'(mineLanded), 64'd0);
        resetN = 1'b1;
        @(posedge clk); #1;

        enable = 1'b0;
        do_frame(0, 2'd0, 0, bc);
        check_eq("dis2_busy", 64'(bc), 64'd0);
        check_eq("dis2_active", 64'(mineActive), 64'd0);
        check_eq("dis2_y", 64'(topLeftY), 64'd0);

        enable = 1'b1;
        do_frame(0, 2'd0, 0, bc);
        check_eq("post_busy", 64'(bc), 64'd9);
        check_eq("post_active", 64'(mineActive), 64'b0001);
        check_eq("post_x0", 64'(xpix(0)), 64'(exp_x(spawn_lfsr)));
        check_eq("post_y0", 64'(ypix(0)), 64'd33);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
